cfg_master: RTL

CFG_MASTER -- requirements
Module: cfg_master

---
 rtl/cfg_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cfg_master.sv
// cfg_master: programs one convolution job into a register slave.
// Writes kernel/input dims, params and start, then polls the done bit.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   job_valid/job_ready  job descriptor handshake (ready only in IDLE)
//   job_kw, job_kh       kernel width/height
//   job_iw, job_ih       input width/height
//   job_stride, job_pad  stride and padding
//   job_done, job_err    one-cycle completion pulse, err=timeout abort
//   busy                 high whenever a job is in flight
//   reg_write/addr/wdata registered write port to the slave
//   reg_rdata            combinational read data for reg_addr
//
// Build option: define CFG_MASTER_TIMEOUT_EN to abort a job whose
// ARM/POLL phase runs TIMEOUT_CYCLES cycles; otherwise job_err is 0
// and the poll waits forever.
module cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [3:0]  job_kw,
  input  logic [3:0]  job_kh,
  input  logic [7:0]  job_iw,
  input  logic [7:0]  job_ih,
  input  logic [3:0]  job_stride,
  input  logic [3:0]  job_pad,
  output logic        job_done,
  output logic        job_err,
  output logic        busy,
  output logic        reg_write,
  output logic [3:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR_KDIM,
    WR_IDIM,
    WR_PARAM,
    WR_START,
    ARM,
    POLL,
    FIN
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [3:0] kw_q;
  logic [3:0] kh_q;
  logic [7:0] iw_q;
  logic [7:0] ih_q;
  logic [3:0] stride_q;
  logic [3:0] pad_q;

  logic        write_n;
  logic [3:0]  addr_n;
  logic [31:0] wdata_n;
  logic        tmo_hit;
  logic        accept;
  logic        rdata_unused;

  // Only the done bit of the status word matters here.
  assign rdata_unused = ^reg_rdata[31:1];

  assign job_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = job_valid && (state_q == IDLE);

`ifdef CFG_MASTER_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_n;
  logic        waiting;

  assign waiting = (state_q == ARM) || (state_q == POLL);

  // tmo_q counts ARM/POLL cycles already completed; the cycle that
  // would make it TIMEOUT_CYCLES is the last one.
  assign tmo_hit = waiting &&
                   ((32'(tmo_q) + 32'd1) == TIMEOUT_CYCLES);

  // A real done in POLL wins over a simultaneous timeout.
  assign err_n = tmo_hit &&
                 !((state_q == POLL) && reg_rdata[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= 16'd0;
    end else if (state_q == WR_START) begin
      tmo_q <= 16'd0;
    end else if (waiting) begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_err <= 1'b0;
    end else begin
      job_err <= err_n;
    end
  end
`else
  localparam int unsigned tmo_unused = TIMEOUT_CYCLES;

  assign tmo_hit = 1'b0;
  assign job_err = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (job_valid) state_n = WR_KDIM;
      end
      WR_KDIM:  state_n = WR_IDIM;
      WR_IDIM:  state_n = WR_PARAM;
      WR_PARAM: state_n = WR_START;
      WR_START: state_n = ARM;
      // Wait for the previous job's done level to clear first.
      ARM: begin
        if (tmo_hit) begin
          state_n = FIN;
        end else if (!reg_rdata[0]) begin
          state_n = POLL;
        end
      end
      POLL: begin
        if (reg_rdata[0] || tmo_hit) state_n = FIN;
      end
      FIN:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  // WR_KDIM is entered straight from IDLE, before the fields latch.
  always_comb begin
    write_n = 1'b0;
    addr_n  = 4'd0;
    wdata_n = 32'd0;
    unique case (state_n)
      WR_KDIM: begin
        write_n = 1'b1;
        addr_n  = 4'd2;
        wdata_n = {20'b0, job_kh, 4'b0, job_kw};
      end
      WR_IDIM: begin
        write_n = 1'b1;
        addr_n  = 4'd3;
        wdata_n = {16'b0, ih_q, iw_q};
      end
      WR_PARAM: begin
        write_n = 1'b1;
        addr_n  = 4'd4;
        wdata_n = {24'b0, pad_q, stride_q};
      end
      WR_START: begin
        write_n = 1'b1;
        addr_n  = 4'd0;
        wdata_n = 32'h1;
      end
      ARM, POLL: begin
        addr_n = 4'd1;
      end
      default: begin
        write_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reg_write <= 1'b0;
      reg_addr  <= 4'd0;
      reg_wdata <= 32'd0;
      job_done  <= 1'b0;
    end else begin
      state_q   <= state_n;
      reg_write <= write_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      job_done  <= (state_n == FIN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kw_q     <= 4'd0;
      kh_q     <= 4'd0;
      iw_q     <= 8'd0;
      ih_q     <= 8'd0;
      stride_q <= 4'd0;
      pad_q    <= 4'd0;
    end else if (accept) begin
      kw_q     <= job_kw;
      kh_q     <= job_kh;
      iw_q     <= job_iw;
      ih_q     <= job_ih;
      stride_q <= job_stride;
      pad_q    <= job_pad;
    end
  end

endmodule
